// File: rtl/pipeline_result_fifo.sv
// Elastic result queue at the tail of a pipelined unit: absorbs up to DEPTH results
// and presents them in order on a valid/ready handshake.
module pipeline_result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        ins,
  input  logic                         ins_valid,
  output logic                         ins_ready,
  output logic [DATA_WIDTH-1:0]        outs,
  output logic                         outs_valid,
  input  logic                         outs_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  if (DEPTH < 2) begin : g_depth_check
    $error("pipeline_result_fifo: DEPTH must be at least 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  push;
  logic                  pop;

  // All outputs come from registers (and rst), so the pipeline enable never depends on outs_ready.
  assign ins_ready  = !rst && (cnt != FULL_CNT);
  assign outs_valid = !rst && (cnt != '0);
  assign outs       = outs_valid ? mem[rd_ptr] : '0;
  assign count      = rst ? '0 : cnt;

  assign push = ins_valid && ins_ready;
  assign pop  = outs_valid && outs_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ins;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves occupancy unchanged while both pointers move.
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_result_fifo.sv
// Drives a DEPTH=4 and a DEPTH=3 queue with identical stimulus and checks both
// against a queue-based reference model through a negedge scoreboard monitor.
module tb_pipeline_result_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        outs_ready;

  logic        ins_ready4, outs_valid4, ins_ready3, outs_valid3;
  logic [31:0] outs4, outs3;
  logic [2:0]  count4;
  logic [1:0]  count3;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [31:0] exp_q [2][$];
  logic [1:0]  dut_ins_ready, dut_outs_valid;
  logic [31:0] dut_outs  [2];
  logic [31:0] dut_count [2];

  pipeline_result_fifo #(.DATA_WIDTH(32), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready4),
    .outs(outs4), .outs_valid(outs_valid4), .outs_ready(outs_ready), .count(count4)
  );

  pipeline_result_fifo #(.DATA_WIDTH(32), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready3),
    .outs(outs3), .outs_valid(outs_valid3), .outs_ready(outs_ready), .count(count3)
  );

  assign dut_ins_ready  = {ins_ready3, ins_ready4};
  assign dut_outs_valid = {outs_valid3, outs_valid4};
  assign dut_outs[0]    = outs4;
  assign dut_outs[1]    = outs3;
  assign dut_count[0]   = 32'(count4);
  assign dut_count[1]   = 32'(count3);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int depth_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] d, input logic rdy);
    rst        = r;
    ins_valid  = v;
    ins        = d;
    outs_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue contents are the occupancy; acceptance follows the handshake rules.
  always @(negedge clk) begin
    int  sz;
    bit  exp_valid, exp_ready;
    for (int k = 0; k < 2; k++) begin
      sz        = exp_q[k].size();
      exp_valid = !rst && (sz != 0);
      exp_ready = !rst && (sz < depth_of(k));
      checkOutput($sformatf("d%0d ins_ready", depth_of(k)), 32'(dut_ins_ready[k]), 32'(exp_ready));
      checkOutput($sformatf("d%0d outs_valid", depth_of(k)), 32'(dut_outs_valid[k]), 32'(exp_valid));
      checkOutput($sformatf("d%0d count", depth_of(k)), dut_count[k], rst ? 32'd0 : 32'(sz));
      checkOutput($sformatf("d%0d outs", depth_of(k)), dut_outs[k], exp_valid ? exp_q[k][0] : 32'd0);
      if (rst) begin
        exp_q[k].delete();
      end else begin
        if (exp_valid && outs_ready) void'(exp_q[k].pop_front());
        if (ins_valid && exp_ready) exp_q[k].push_back(ins);
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; ins_valid = 1'b0; ins = '0; outs_ready = 1'b0;

    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Single pass
    applyStimulus(0, 1, 32'hA5A5_0001, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);

    // Fill with consumer stalled, then hold value 5 against a full queue
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 32'(i), 0);
    @(negedge clk);
    checkOutput("fill count4", 32'(count4), 32'd4);
    checkOutput("fill ins_ready4", 32'(ins_ready4), 32'd0);
    applyStimulus(0, 1, 5, 0);
    applyStimulus(0, 1, 5, 1);
    applyStimulus(0, 1, 5, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1);

    // Simultaneous push/pop at occupancy 2
    applyStimulus(0, 1, 32'h100, 0);
    applyStimulus(0, 1, 32'h101, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 32'h102 + 32'(i), 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);

    // Reset mid-stream at occupancy 3
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'hDEAD_0000 + 32'(i), 0);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 32'h0000_BEEF, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 60),
                    $urandom, ($urandom_range(0, 99) < 50));
    end

    guard = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && guard < 20) begin
      applyStimulus(0, 0, 0, 1);
      guard++;
    end
    checkOutput("drain within bound", 32'(guard < 20), 32'd1);
    applyStimulus(0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
